// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared widths and read-owner encoding for the dmem arbiter
package dmem_arb_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_PROC = 2'd1, OWN_DBG = 2'd2} rd_owner_e;
endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating starvation counter with clear
module dmem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic at_limit
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? 4'd0 : (cnt_q == LIM) ? cnt_q : cnt_q + 4'd1;
    at_limit = cnt_q == LIM;
  end
  always_ff @(posedge clock)
    if (!reset) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: processor/debug arbiter for the shared single-port dmem
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              proc_req,
  input  logic              proc_wren,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_gnt,
  output logic              proc_stall,
  output logic              proc_rvalid,
  output logic [DATA_W-1:0] proc_rdata,
  input  logic              dbg_req,
  input  logic              dbg_wren,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);
  logic at_limit;
  rd_owner_e rd_owner_q, rd_owner_d;
  dmem_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clock(clock),
    .reset(reset),
    .clr(~dbg_req | dbg_gnt),
    .at_limit(at_limit)
  );
  always_comb begin
    dbg_gnt = reset & dbg_req & (~proc_req | at_limit);
    proc_gnt = reset & proc_req & ~dbg_gnt;
    proc_stall = proc_req & ~proc_gnt;
    address_dmem = dbg_gnt ? dbg_addr : proc_addr;
    data = dbg_gnt ? dbg_wdata : proc_wdata;
    wren = dbg_gnt ? dbg_wren : proc_gnt & proc_wren;
    rd_owner_d = (proc_gnt & ~proc_wren) ? OWN_PROC : (dbg_gnt & ~dbg_wren) ? OWN_DBG : OWN_NONE;
    proc_rvalid = rd_owner_q == OWN_PROC;
    dbg_rvalid = rd_owner_q == OWN_DBG;
    proc_rdata = proc_rvalid ? q_dmem : '0;
    dbg_rdata = dbg_rvalid ? q_dmem : '0;
  end
  always_ff @(posedge clock)
    if (!reset) rd_owner_q <= OWN_NONE;
    else rd_owner_q <= rd_owner_d;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a syncram model
module tb_dmem_arbiter;
  localparam int LIMIT = 4;
  localparam logic [1:0] E_NONE = 2'd0, E_PROC = 2'd1, E_DBG = 2'd2;
  typedef struct {
    logic [1:0]  own;
    logic [31:0] d;
  } exp_t;
  logic clock = 0, reset = 0;
  logic proc_req = 0, proc_wren = 0, dbg_req = 0, dbg_wren = 0;
  logic [11:0] proc_addr = 0, dbg_addr = 0, address_dmem;
  logic [31:0] proc_wdata = 0, dbg_wdata = 0, proc_rdata, dbg_rdata, data, q_dmem;
  logic proc_gnt, proc_stall, proc_rvalid, dbg_gnt, dbg_rvalid, wren;
  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  exp_t sb[$];
  int errors = 0, checks = 0, cnt = 0;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .proc_req(proc_req), .proc_wren(proc_wren), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_gnt(proc_gnt), .proc_stall(proc_stall), .proc_rvalid(proc_rvalid), .proc_rdata(proc_rdata),
    .dbg_req(dbg_req), .dbg_wren(dbg_wren), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input bit drop_rst = 0);
    logic pg, dg;
    exp_t e, n;
    #3;
    dg = reset && dbg_req && (!proc_req || cnt == LIMIT);
    pg = reset && proc_req && !(dbg_req && cnt == LIMIT);
    chk({tag, " proc_gnt"}, 64'(proc_gnt), 64'(pg));
    chk({tag, " dbg_gnt"}, 64'(dbg_gnt), 64'(dg));
    chk({tag, " proc_stall"}, 64'(proc_stall), 64'(proc_req && !pg));
    chk({tag, " wren"}, 64'(wren), 64'(dg ? dbg_wren : pg && proc_wren));
    if (pg || dg) chk({tag, " addr"}, 64'(address_dmem), 64'(dg ? dbg_addr : proc_addr));
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 64'(1), 64'(0));
      e = '{E_NONE, 32'h0};
    end else e = sb.pop_front();
    chk({tag, " proc_rvalid"}, 64'(proc_rvalid), 64'(e.own == E_PROC));
    chk({tag, " dbg_rvalid"}, 64'(dbg_rvalid), 64'(e.own == E_DBG));
    chk({tag, " proc_rdata"}, 64'(proc_rdata), 64'(e.own == E_PROC ? e.d : 32'h0));
    chk({tag, " dbg_rdata"}, 64'(dbg_rdata), 64'(e.own == E_DBG ? e.d : 32'h0));
    chk({tag, " rvalid_both"}, 64'(proc_rvalid && dbg_rvalid), 64'(0));
    if (pg && proc_wren) ref_mem[proc_addr] = proc_wdata;
    if (dg && dbg_wren) ref_mem[dbg_addr] = dbg_wdata;
    if (drop_rst) reset = 0;
    #1;
    n = '{E_NONE, 32'h0};
    if (reset && pg && !proc_wren) n = '{E_PROC, ref_mem[proc_addr]};
    if (reset && dg && !dbg_wren) n = '{E_DBG, ref_mem[dbg_addr]};
    sb.push_back(n);
    cnt = (!reset || !dbg_req || dg) ? 0 : (cnt == LIMIT ? cnt : cnt + 1);
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic pr, input logic pw, input logic [11:0] pa, input logic [31:0] pd,
                       input logic dr, input logic dw, input logic [11:0] da, input logic [31:0] dd);
    proc_req = pr; proc_wren = pw; proc_addr = pa; proc_wdata = pd;
    dbg_req = dr; dbg_wren = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
      ref_mem[i] = mem[i];
    end
    mem[12'h010] = 32'hDEADBEEF; ref_mem[12'h010] = 32'hDEADBEEF;
    mem[12'h001] = 32'h1111_0001; ref_mem[12'h001] = 32'h1111_0001;
    mem[12'h002] = 32'h2222_0002; ref_mem[12'h002] = 32'h2222_0002;
    sb.push_back('{E_NONE, 32'h0});
    drive(1, 0, 12'h010, 0, 1, 0, 12'h030, 0);
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) step("reset_hold");
    reset = 1;
    step("release");
    drive(1, 0, 12'h010, 0, 0, 0, 12'h030, 0);
    step("proc_read");
    drive(0, 0, 12'h000, 0, 1, 1, 12'h020, 32'hCAFEF00D);
    step("dbg_write");
    drive(1, 0, 12'h020, 0, 0, 0, 12'h000, 0);
    step("proc_read_after_write");
    chk("dbg_write_mem", 64'(ref_mem[12'h020]), 64'(32'hCAFEF00D));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("idle");
    drive(1, 0, 12'h010, 0, 1, 0, 12'h002, 0);
    for (int i = 0; i < 6; i++) begin
      #3;
      chk("starve_dbg_gnt_seq", 64'(dbg_gnt), 64'(i == 4));
      chk("starve_proc_stall_seq", 64'(proc_stall), 64'(i == 4));
      #1;
      cnt = cnt;
      #0;
      step("starve", 0);
      #0;
    end
    drive(1, 0, 12'h001, 0, 0, 0, 0, 0);
    step("interleave_proc");
    drive(0, 0, 0, 0, 1, 0, 12'h002, 0);
    step("interleave_dbg");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("interleave_drain");
    drive(1, 1, 12'h040, 32'h0BAD_F00D, 1, 0, 12'h040, 0);
    step("same_addr_write");
    drive(0, 0, 0, 0, 1, 0, 12'h040, 0);
    step("same_addr_read");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("same_addr_drain");
    drive(1, 0, 12'h001, 0, 0, 0, 0, 0);
    step("mid_reset_read", 1);
    drive(1, 0, 12'h002, 0, 1, 0, 12'h010, 0);
    step("mid_reset_hold");
    reset = 1;
    step("mid_reset_release");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("final_drain");
    step("final_idle");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
